// File: rtl/dda_sequencer.sv
// Byte-stream command sequencer for the Lorenz DDA integrator: holds the
// parameter register file, gates the integrator enable and streams x/y/z snapshots.

module dda_seq_regs #(
    parameter int REG_SIZE = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic [8*REG_SIZE-1:0] regs
);
    // Byte 0 sits in the top byte, so each even/odd pair reads out as {MSB, LSB}.
    localparam logic [8*REG_SIZE-1:0] RST_VAL = 112'hC000_14CD_7240_6A00_5555_7300_0400;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= RST_VAL;
        end else begin
            for (int k = 0; k < REG_SIZE; k++) begin
                if (wr_en && wr_addr == 4'(k)) begin
                    regs[8*(REG_SIZE-1-k) +: 8] <= wr_data;
                end
            end
        end
    end
endmodule

// state   | meaning
// IDLE    | waiting for a header byte
// WDATA   | waiting for the data byte of a WRITE
// STEPCNT | waiting for the step-count byte of a STEP
// RUN     | integrator enabled, step counter running down
// LOAD    | one-cycle integrator reset / IC reload
// SEND    | streaming the six snapshot bytes
module dda_sequencer #(
    parameter int N        = 16,
    parameter int REG_SIZE = 14,
    parameter int OUT_SIZE = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic [N-1:0] icx,
    output logic [N-1:0] icy,
    output logic [N-1:0] icz,
    output logic [N-1:0] sigma,
    output logic [N-1:0] beta,
    output logic [N-1:0] rho,
    output logic [N-1:0] dt,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic         dda_en,
    output logic         dda_rst,
    output logic         busy,
    output logic         err
);
    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_STEPCNT, S_RUN, S_LOAD, S_SEND
    } state_t;

    localparam logic [3:0] OP_CLR   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STEP  = 4'h3;
    localparam logic [3:0] OP_READ  = 4'h4;
    localparam logic [3:0] LAST_ADDR = 4'(REG_SIZE - 1);
    localparam logic [2:0] LAST_IDX  = 3'(OUT_SIZE - 1);

    state_t               state, state_nxt;
    logic [3:0]           addr_q;
    logic [8:0]           cnt_q;
    logic [2:0]           idx_q;
    logic [3*N-1:0]       shadow_q;
    logic [8*REG_SIZE-1:0] regs;
    logic                 in_fire, out_fire;
    logic                 wr_en, err_set, err_clr;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign in_ready = (state == S_IDLE) || (state == S_WDATA) || (state == S_STEPCNT);
    assign busy     = (state != S_IDLE);

    dda_seq_regs #(.REG_SIZE(REG_SIZE)) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_data (in_data),
        .regs    (regs)
    );

    assign icx   = regs[111:96];
    assign icy   = regs[95:80];
    assign icz   = regs[79:64];
    assign sigma = regs[63:48];
    assign beta  = regs[47:32];
    assign rho   = regs[31:16];
    assign dt    = regs[15:0];

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_fire) begin
                    case (in_data[7:4])
                        OP_CLR:   err_clr   = 1'b1;
                        OP_WRITE: state_nxt = S_WDATA;
                        OP_LOAD:  state_nxt = S_LOAD;
                        OP_STEP:  state_nxt = S_STEPCNT;
                        OP_READ:  state_nxt = S_SEND;
                        default:  err_set   = 1'b1;
                    endcase
                end
            end
            S_WDATA: begin
                if (in_fire) begin
                    state_nxt = S_IDLE;
                    if (addr_q <= LAST_ADDR) wr_en = 1'b1;
                    else                     err_set = 1'b1;
                end
            end
            S_STEPCNT: if (in_fire) state_nxt = S_RUN;
            S_RUN:     if (cnt_q <= 9'd1) state_nxt = S_IDLE;
            S_LOAD:    state_nxt = S_IDLE;
            S_SEND:    if (out_fire && idx_q == LAST_IDX) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= 4'd0;
            cnt_q     <= 9'd0;
            idx_q     <= 3'd0;
            shadow_q  <= '0;
            err       <= 1'b0;
            dda_en    <= 1'b0;
            dda_rst   <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            dda_en    <= (state_nxt == S_RUN);
            dda_rst   <= (state_nxt == S_LOAD);
            out_valid <= (state_nxt == S_SEND);
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            if (state == S_IDLE && in_fire) begin
                addr_q <= in_data[3:0];
                if (in_data[7:4] == OP_READ) shadow_q <= {x, y, z};
            end
            // A count byte of zero stands for 256 steps.
            if (state == S_STEPCNT && in_fire)
                cnt_q <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            else if (state == S_RUN && cnt_q != 9'd0)
                cnt_q <= cnt_q - 9'd1;
            if (state == S_SEND && out_fire)
                idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        out_data = 8'h00;
        case (idx_q)
            3'd0:    out_data = shadow_q[47:40];
            3'd1:    out_data = shadow_q[39:32];
            3'd2:    out_data = shadow_q[31:24];
            3'd3:    out_data = shadow_q[23:16];
            3'd4:    out_data = shadow_q[15:8];
            3'd5:    out_data = shadow_q[7:0];
            default: out_data = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_dda_sequencer.sv
// Randomised self-checking bench for dda_sequencer against a byte-array
// model of the parameter file, error flag and command timing.

module tb_dda_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] icx, icy, icz, sigma, beta, rho, dt;
    logic [15:0] x, y, z;
    logic        dda_en, dda_rst, busy, err;

    always #5 clk = ~clk;

    dda_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .icx(icx), .icy(icy), .icz(icz), .sigma(sigma), .beta(beta),
        .rho(rho), .dt(dt), .x(x), .y(y), .z(z),
        .dda_en(dda_en), .dda_rst(dda_rst), .busy(busy), .err(err)
    );

    int n_err = 0;
    int n_chk = 0;
    logic [7:0] mreg [14];
    logic       merr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        mreg = '{8'hC0, 8'h00, 8'h14, 8'hCD, 8'h72, 8'h40, 8'h6A, 8'h00,
                 8'h55, 8'h55, 8'h73, 8'h00, 8'h04, 8'h00};
        merr = 1'b0;
    endtask

    function automatic logic [15:0] dut_word(input int k);
        case (k)
            0: return icx;
            1: return icy;
            2: return icz;
            3: return sigma;
            4: return beta;
            5: return rho;
            default: return dt;
        endcase
    endfunction

    task automatic check_state();
        for (int k = 0; k < 7; k++)
            chk($sformatf("param%0d", k), dut_word(k), {mreg[2*k], mreg[2*k+1]});
        chk("err", err, merr);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 1000) begin
            tick();
            w++;
        end
        if (!in_ready) chk("in_ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_step(input logic [7:0] n);
        int exp_len = (n == 8'd0) ? 256 : int'(n);
        int len = 0;
        int bad = 0;
        send_byte(8'h30);
        send_byte(n);
        while (dda_en && len < 400) begin
            if (in_ready) bad++;
            len++;
            tick();
        end
        chk("step_len", len, exp_len);
        chk("step_in_ready_low", bad, 0);
        chk("step_done_ready", in_ready, 1'b1);
    endtask

    task automatic do_load();
        send_byte(8'h20);
        chk("load_pulse", {dda_rst, in_ready}, 2'b10);
        tick();
        chk("load_end", {dda_rst, in_ready}, 2'b01);
    endtask

    task automatic do_read(input logic [15:0] xv, input logic [15:0] yv,
                           input logic [15:0] zv, input bit rand_stall);
        logic [47:0] snap = {xv, yv, zv};
        logic [7:0]  eb;
        int got = 0;
        int cyc = 0;
        x = xv; y = yv; z = zv;
        out_ready = 1'b0;
        send_byte(8'h40);
        while (got < 6 && cyc < 200) begin
            x = 16'($urandom);
            y = 16'($urandom);
            z = 16'($urandom);
            out_ready = rand_stall ? 1'($urandom) : (cyc >= 3);
            eb = 8'(snap >> (8 * (5 - got)));
            chk("rd_byte", {out_valid, out_data}, {1'b1, eb});
            if (out_ready) got++;
            cyc++;
            tick();
        end
        out_ready = 1'b0;
        chk("rd_count", got, 6);
        chk("rd_done", {out_valid, busy}, 2'b00);
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] d;
        int op;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        x = 16'h0; y = 16'h0; z = 16'h0;
        m_reset();
        #12;
        chk("rst_outs", {dda_en, dda_rst, busy, out_valid, out_data, err}, {4'b0100, 8'h00, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_dda_rst_first", dda_rst, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        check_state();
        tick();
        chk("rst_dda_rst_drop", dda_rst, 1'b0);

        send_byte(8'h1C); send_byte(8'h08);
        mreg[12] = 8'h08;
        chk("dt_write", dt, 16'h0800);
        send_byte(8'h1F); send_byte(8'hAA);
        merr = 1'b1;
        check_state();
        send_byte(8'h00);
        merr = 1'b0;
        check_state();

        do_step(8'd5);
        do_step(8'd0);
        check_state();

        do_read(16'h1234, 16'hABCD, 16'h7240, 1'b0);
        check_state();

        do_load();
        send_byte(8'h70);
        merr = 1'b1;
        check_state();

        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    a = 4'($urandom_range(0, 15));
                    d = 8'($urandom);
                    send_byte({4'h1, a});
                    send_byte(d);
                    if (a < 4'd14) mreg[a] = d;
                    else           merr = 1'b1;
                end
                1: begin
                    send_byte({4'h0, 4'($urandom)});
                    merr = 1'b0;
                end
                2: begin
                    send_byte({4'($urandom_range(5, 15)), 4'($urandom)});
                    merr = 1'b1;
                end
                3: do_step(8'($urandom_range(1, 12)));
                4: do_load();
                default: do_read(16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            endcase
            check_state();
        end

        send_byte(8'h1D); send_byte(8'h5A);
        send_byte(8'h30); send_byte(8'h10);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_en", {dda_en, out_valid, busy}, 3'b000);
        #2 rst_n = 1'b1;
        m_reset();
        chk("abort_dda_rst", dda_rst, 1'b1);
        tick();
        chk("abort_ready", {in_ready, dda_rst, dda_en}, 3'b100);
        check_state();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
